// File: rtl/memory_stage_pkg.sv
// Shared types for the execute->memory->writeback pipeline boundary.
// Operation codes and the packed bundles carried between stages.
package memory_stage_pkg;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_t;

    typedef struct packed {
        op_t op;
    } control_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  dst;
        control_t    ctl;
        logic [63:0] result;
        logic [63:0] memwrite_data;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  dst;
        control_t    ctl;
        logic [63:0] result;
    } memory_data_t;

endpackage

// File: rtl/memory_stage.sv
// Memory stage: registers execute results and runs load/store bus transactions.
// 1 edge for non-mem/misaligned ops, 3+ edges for bus ops; stallM holds execute while busy.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  execute_data_t dataE,
    output logic          dreq_valid,
    output logic [63:0]   dreq_addr,
    output logic [2:0]    dreq_size,
    output logic [7:0]    dreq_strobe,
    output logic [63:0]   dreq_data,
    input  logic          dresp_addr_ok,
    input  logic          dresp_data_ok,
    input  logic [63:0]   dresp_data,
    output logic          stallM,
    output memory_data_t  dataM,
    output logic          misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, stateNext;
    logic [2:0]  offset;
    logic        isLoad, isStore, signedLoad, isMem, offsetBad;
    logic [1:0]  accSize;
    logic [7:0]  strobeBase;
    logic [63:0] rdata, loadShift, loadResult, finalResult;
    logic [63:0] reqAddr, reqData;
    logic [2:0]  reqSize;
    logic [7:0]  reqStrobe;
    logic        startReq, latchData, captureEn;

    assign offset = dataE.result[2:0];

    always_comb begin
        isLoad     = 1'b0;
        isStore    = 1'b0;
        signedLoad = 1'b0;
        accSize    = 2'd0;
        case (dataE.ctl.op)
            OP_LB:   begin isLoad = 1'b1; signedLoad = 1'b1; accSize = 2'd0; end
            OP_LH:   begin isLoad = 1'b1; signedLoad = 1'b1; accSize = 2'd1; end
            OP_LW:   begin isLoad = 1'b1; signedLoad = 1'b1; accSize = 2'd2; end
            OP_LD:   begin isLoad = 1'b1; accSize = 2'd3; end
            OP_LBU:  begin isLoad = 1'b1; accSize = 2'd0; end
            OP_LHU:  begin isLoad = 1'b1; accSize = 2'd1; end
            OP_LWU:  begin isLoad = 1'b1; accSize = 2'd2; end
            OP_SB:   begin isStore = 1'b1; accSize = 2'd0; end
            OP_SH:   begin isStore = 1'b1; accSize = 2'd1; end
            OP_SW:   begin isStore = 1'b1; accSize = 2'd2; end
            OP_SD:   begin isStore = 1'b1; accSize = 2'd3; end
            default: ;
        endcase
    end

    assign isMem = dataE.valid && (isLoad || isStore);

    always_comb begin
        offsetBad  = 1'b0;
        strobeBase = 8'h01;
        case (accSize)
            2'd0:    begin offsetBad = 1'b0;          strobeBase = 8'h01; end
            2'd1:    begin offsetBad = offset[0];     strobeBase = 8'h03; end
            2'd2:    begin offsetBad = |offset[1:0];  strobeBase = 8'h0F; end
            default: begin offsetBad = |offset;       strobeBase = 8'hFF; end
        endcase
    end

    // Read data arrives as a full aligned doubleword; bring the addressed bytes to lane 0.
    assign loadShift = rdata >> {offset, 3'b000};

    always_comb begin
        case (accSize)
            2'd0:    loadResult = {{56{signedLoad & loadShift[7]}},  loadShift[7:0]};
            2'd1:    loadResult = {{48{signedLoad & loadShift[15]}}, loadShift[15:0]};
            2'd2:    loadResult = {{32{signedLoad & loadShift[31]}}, loadShift[31:0]};
            default: loadResult = loadShift;
        endcase
    end

    assign finalResult = (state == DONE && isLoad) ? loadResult : dataE.result;

    always_comb begin
        stateNext = state;
        startReq  = 1'b0;
        latchData = 1'b0;
        captureEn = 1'b0;
        case (state)
            IDLE: begin
                if (isMem && !offsetBad) begin
                    stateNext = REQ;
                    startReq  = 1'b1;
                end else begin
                    captureEn = 1'b1;
                end
            end
            REQ: begin
                if (dresp_addr_ok && dresp_data_ok) begin
                    latchData = 1'b1;
                    stateNext = DONE;
                end else if (dresp_addr_ok) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (dresp_data_ok) begin
                    latchData = 1'b1;
                    stateNext = DONE;
                end
            end
            default: begin
                captureEn = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

    assign stallM     = isMem && !offsetBad && (state != DONE);
    assign dreq_valid = (state == REQ);
    assign dreq_addr  = reqAddr;
    assign dreq_size  = reqSize;
    assign dreq_strobe = reqStrobe;
    assign dreq_data  = reqData;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            reqAddr    <= '0;
            reqSize    <= '0;
            reqStrobe  <= '0;
            reqData    <= '0;
            rdata      <= '0;
            dataM      <= '0;
            misaligned <= 1'b0;
        end else begin
            state <= stateNext;
            if (startReq) begin
                reqAddr   <= dataE.result;
                reqSize   <= {1'b0, accSize};
                reqStrobe <= isStore ? (strobeBase << offset) : 8'h00;
                reqData   <= isStore ? (dataE.memwrite_data << {offset, 3'b000}) : 64'd0;
            end
            if (latchData) begin
                rdata <= dresp_data;
            end
            // Stall cycles present bubbles to writeback; the other fields are don't-care.
            if (captureEn) begin
                dataM.valid  <= dataE.valid;
                dataM.pc     <= dataE.pc;
                dataM.dst    <= dataE.dst;
                dataM.ctl    <= dataE.ctl;
                dataM.result <= finalResult;
                misaligned   <= isMem && offsetBad;
            end else begin
                dataM.valid <= 1'b0;
                misaligned  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a byte-level reference model.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          resetn;
    execute_data_t dataE;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_addr_ok;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;
    logic          stallM;
    memory_data_t  dataM;
    logic          misaligned;

    int nChecks = 0;
    int nFails  = 0;

    memory_stage dut (
        .clk(clk), .resetn(resetn), .dataE(dataE),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .stallM(stallM), .dataM(dataM), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- reference model ----------------
    function automatic int opBytes(input op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_LWU, OP_SW: return 4;
            OP_LD, OP_SD:         return 8;
            default:              return 0;
        endcase
    endfunction

    function automatic logic isLoadOp(input op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
    endfunction

    function automatic logic isSignedOp(input op_t op);
        return op inside {OP_LB, OP_LH, OP_LW};
    endfunction

    function automatic logic [2:0] sizeModel(input int n);
        return (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : (n == 4) ? 3'd2 : 3'd3;
    endfunction

    function automatic logic [63:0] loadModel(input op_t op, input logic [63:0] addr, input logic [63:0] rd);
        int n, off;
        logic [63:0] v;
        n = opBytes(op);
        off = int'(addr[2:0]);
        v = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < n)
                v[8*k +: 8] = rd[8*(off+k) +: 8];
            else if (isSignedOp(op) && v[8*n-1])
                v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic [7:0] strobeModel(input op_t op, input logic [63:0] addr);
        int n, off;
        logic [7:0] s;
        n = opBytes(op);
        off = int'(addr[2:0]);
        s = '0;
        if (!isLoadOp(op))
            for (int k = 0; k < 8; k++) s[k] = (k >= off) && (k < off + n);
        return s;
    endfunction

    function automatic logic [63:0] storeDataModel(input op_t op, input logic [63:0] addr, input logic [63:0] wd);
        int off;
        logic [63:0] v;
        off = int'(addr[2:0]);
        v = '0;
        if (!isLoadOp(op))
            for (int k = 0; k < 8; k++) if (k >= off) v[8*k +: 8] = wd[8*(k-off) +: 8];
        return v;
    endfunction

    // Presents one op at a negedge and walks it through the bus protocol with the
    // given addr_ok delay (REQ cycles before accept) and data_ok delay (cycles after accept).
    task automatic runOp(input op_t op, input logic vld, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input int aDly, input int dDly);
        int n;
        logic mem, mis;
        logic [63:0] expRes, pc;
        logic [4:0] dst;
        n   = opBytes(op);
        mem = vld && (n != 0);
        mis = mem && ((int'(addr[2:0]) % n) != 0);
        expRes = (isLoadOp(op) && !mis) ? loadModel(op, addr, rdata) : addr;
        pc  = rand64();
        dst = 5'($urandom_range(0, 31));

        dataE.valid = vld;
        dataE.pc = pc;
        dataE.dst = dst;
        dataE.ctl.op = op;
        dataE.result = addr;
        dataE.memwrite_data = wdata;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'($urandom_range(0, 1));
        dresp_data = rand64();
        #1;
        if (!mem || mis) begin
            checkVal("stall_nonmem", stallM, 0);
            checkVal("dreq_valid_nonmem", dreq_valid, 0);
            @(negedge clk);
            checkVal("dataM_valid_1edge", dataM.valid, vld);
            if (vld) begin
                checkVal("result_nonmem", dataM.result, expRes);
                checkVal("misaligned_flag", misaligned, mis);
                checkVal("dataM_dst", dataM.dst, dst);
            end
        end else begin
            checkVal("stall_idle", stallM, 1);
            checkVal("dreq_valid_idle", dreq_valid, 0);
            for (int i = 0; i <= aDly; i++) begin
                @(negedge clk);
                dresp_addr_ok = (i == aDly);
                dresp_data_ok = (i == aDly) ? (dDly == 0) : 1'($urandom_range(0, 1));
                dresp_data = (i == aDly && dDly == 0) ? rdata : rand64();
                #1;
                checkVal("dreq_valid_req", dreq_valid, 1);
                checkVal("stall_req", stallM, 1);
                checkVal("dataM_valid_req", dataM.valid, 0);
                checkVal("dreq_addr", dreq_addr, addr);
                checkVal("dreq_size", dreq_size, sizeModel(n));
                checkVal("dreq_strobe", dreq_strobe, strobeModel(op, addr));
                checkVal("dreq_data", dreq_data, storeDataModel(op, addr, wdata));
            end
            for (int i = 1; i <= dDly; i++) begin
                @(negedge clk);
                dresp_addr_ok = 1'b0;
                dresp_data_ok = (i == dDly);
                dresp_data = (i == dDly) ? rdata : rand64();
                #1;
                checkVal("dreq_valid_wait", dreq_valid, 0);
                checkVal("stall_wait", stallM, 1);
            end
            @(negedge clk);
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            dresp_data = rand64();
            #1;
            checkVal("stall_done", stallM, 0);
            checkVal("dataM_valid_done", dataM.valid, 0);
            @(negedge clk);
            checkVal("dataM_valid_out", dataM.valid, 1);
            checkVal("result_mem", dataM.result, expRes);
            checkVal("dataM_pc", dataM.pc, pc);
            checkVal("misaligned_mem", misaligned, 0);
        end
    endtask

    op_t opList [13] = '{OP_NOP, OP_ADD, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU,
                         OP_LHU, OP_LWU, OP_SB, OP_SH, OP_SW, OP_SD};

    initial begin
        logic [63:0] a;
        resetn = 1'b0;
        dataE = '0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data = '0;
        repeat (2) @(negedge clk);
        checkVal("rst_dreq_valid", dreq_valid, 0);
        checkVal("rst_dreq_addr", dreq_addr, 0);
        checkVal("rst_dreq_strobe", dreq_strobe, 0);
        checkVal("rst_dataM_valid", dataM.valid, 0);
        checkVal("rst_misaligned", misaligned, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases
        runOp(OP_LD, 1'b1, 64'h8000_0010, 64'h0, 64'h1122334455667788, 0, 0);
        runOp(OP_LB, 1'b1, 64'h8000_0013, 64'h0, 64'h00000000_80000000, 0, 0);
        runOp(OP_LBU, 1'b1, 64'h8000_0013, 64'h0, 64'h00000000_80000000, 0, 0);
        runOp(OP_SH, 1'b1, 64'h8000_0016, 64'hABCD, 64'h0, 0, 0);
        runOp(OP_SW, 1'b1, 64'h8000_0024, 64'hDEADBEEF, 64'h0, 2, 3);
        runOp(OP_LW, 1'b1, 64'h8000_0002, 64'h0, 64'h0, 0, 0);
        runOp(OP_LD, 1'b0, 64'h8000_0008, 64'h0, 64'h0, 0, 0);

        // Reset while waiting for data
        dataE.valid = 1'b1;
        dataE.ctl.op = OP_LD;
        dataE.result = 64'h8000_0040;
        @(negedge clk);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b0;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        #1;
        checkVal("wait_before_reset", dreq_valid, 0);
        @(negedge clk);
        resetn = 1'b0;
        dataE = '0;
        #1;
        checkVal("midrst_dreq_valid", dreq_valid, 0);
        checkVal("midrst_dreq_addr", dreq_addr, 0);
        checkVal("midrst_dataM_valid", dataM.valid, 0);
        @(negedge clk);
        resetn = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data = rand64();
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        checkVal("late_dataok_valid", dataM.valid, 0);
        checkVal("late_dataok_dreq", dreq_valid, 0);
        runOp(OP_ADD, 1'b1, 64'd5, 64'h0, 64'h0, 0, 0);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            a = {32'h8000_0000, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            runOp(opList[$urandom_range(0, 12)], ($urandom_range(0, 7) != 0), a,
                  rand64(), rand64(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory (M) stage: registers what the execute stage produces and, for loads and stores, runs a data-bus transaction. It sits between execute and writeback. It takes `dataE`, drives a valid/addr_ok/data_ok data-bus handshake, aligns and extends load data, and forms byte strobes for stores. It stalls upstream while a transaction is outstanding and delivers a registered `dataM` to writeback.

## Interface
- Parameters: none.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `dataE` in execute_data_t: fields used are `valid`, `pc`, `dst`, `ctl` (`op`), `result` and `memwrite_data`.
  - For loads and stores, `result` is the effective address.
- `dreq_valid` out 1: bus request.
- `dreq_addr` out 64: address, passed through unaligned.
- `dreq_size` out 3: log2 of the byte count (0/1/2/3 = B/H/W/D).
- `dreq_strobe` out 8: byte write enables; 0 for loads.
- `dreq_data` out 64: write data, already shifted to byte lane.
- `dresp_addr_ok` in 1: request accepted.
- `dresp_data_ok` in 1: data phase complete.
- `dresp_data` in 64: read data as a full aligned doubleword.
- `stallM` out 1: upstream must hold `dataE` stable.
- `dataM` out memory_data_t: fields `valid`, `pc`, `dst`, `ctl`, `result`.
- `misaligned` out 1: registered; qualifies `dataM`.

## Operation
- Memory op (mem): `ctl.op` is one of LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD, and `dataE.valid` = 1.
- FSM states are IDLE, REQ, WAIT and DONE.
- IDLE:
  - Aligned mem → REQ.
  - Any other input, including non-mem ops, bubbles and misaligned mem, is captured into `dataM` the same edge; state stays IDLE.
- REQ: `dreq_valid` = 1.
  - `addr_ok` and `data_ok` in the same cycle → latch `dresp_data`, go to DONE.
  - `addr_ok` only → WAIT.
  - Otherwise stay in REQ.
  - `data_ok` without `addr_ok` is ignored.
- WAIT: `dreq_valid` = 0. `data_ok` → latch `dresp_data`, go to DONE.
- DONE: `stallM` = 0. `dataM` captures the instruction and its final result at the edge; state → IDLE.
- `stallM` = mem && state != DONE. This is combinational and covers IDLE as well.
- Misaligned mem is not held by `stallM`; the IDLE rule takes it.
- Misalignment (offset = `result[2:0]`):
  - H: offset[0] ≠ 0.
  - W: offset[1:0] ≠ 0.
  - D: offset ≠ 0.
  - Response: no bus request, and `dataM` carries `valid` = 1 and `misaligned` = 1.
- Store lanes:
  - `dreq_strobe` = (0x01/0x03/0x0F/0xFF for B/H/W/D) << offset.
  - `dreq_data` = `memwrite_data` << (offset×8); upper bits are truncated to 64.
- Load lanes: x = `rdata` >> (offset×8).
  - LB, LH, LW: sign-extend x[7:0], x[15:0], x[31:0] respectively.
  - LBU, LHU, LWU: zero-extend the same fields.
  - LD: x unchanged.
- `dataM.result`:
  - Loads: the extended value.
  - Stores and non-mem ops: `dataE.result` unchanged.
- `dreq_*` are driven from registered request fields captured on the IDLE→REQ edge. They stay stable until `addr_ok`.

## Timing
- Reset (`resetn` = 0, any time, including mid-transaction):
  - State returns to IDLE immediately.
  - Outputs: `dreq_valid` = 0, `dreq_addr`/`size`/`strobe`/`data` = 0, `dataM` all zeros (`valid` = 0), `misaligned` = 0.
  - An outstanding bus transaction is abandoned; any late `data_ok` arriving in IDLE is ignored.
- Non-mem and misaligned ops: 1-cycle latency, no stall.
- Mem ops: best case `dataM.valid` rises 3 edges after `dataE` is presented (IDLE→REQ→DONE→out). Each extra bus wait cycle adds one edge.
- A bubble (`dataE.valid` = 0) gives `dataM.valid` = 0 at the next edge.
- While stalling, `dataM.valid` = 0, so writeback sees bubbles.
- Back-to-back mem ops: the next op is evaluated in IDLE on the cycle after DONE. The minimum issue interval is 3 cycles.

## Test plan
- LD at 0x8000_0010, `addr_ok` and `data_ok` in the same REQ cycle, data 0x1122334455667788.
  - → `dreq_size` 3, strobe 0x00.
  - → `dataM.result` 0x1122334455667788, `valid` 3 edges after input, `stallM` high for 2 cycles.
- LB at 0x…13, `dresp_data` 0x00000000_80000000.
  - → x[7:0] = 0x80, so `result` 0xFFFF_FFFF_FFFF_FF80.
  - → the same data with LBU gives 0x80.
- SH at 0x…16, `memwrite_data` 0xABCD.
  - → `dreq_strobe` 0xC0, `dreq_data` 0xABCD_0000_0000_0000.
  - → `dataM.result` = address.
- SW with `addr_ok` delayed 2 cycles and `data_ok` 3 cycles after that.
  - → `dreq_*` stable throughout REQ; `dreq_valid` drops in WAIT.
  - → `dataM.valid` follows `data_ok` by 2 edges.
- LW at 0x…02.
  - → no `dreq_valid`.
  - → next edge: `dataM.valid` 1, `misaligned` 1, `stallM` never asserted.
- `resetn` pulsed low while in WAIT.
  - → state IDLE, `dataM.valid` 0.
  - → a `data_ok` pulse afterwards is ignored.
  - → ADD with result 5 then passes: `dataM.result` 5 one edge later.
